// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and defaults for the EX-stage branch resolution unit.
package branch_resolve_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned DEF_BHT_ADDR_LEN = 10;
  localparam int unsigned DEF_CNT_W        = 32;

  // 2-bit saturating direction counter states
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam bht_cnt_e BHT_RESET = WNT;

  // Kind of update applied to one BHT entry
  typedef enum logic [1:0] {
    BHT_DEC    = 2'b00,
    BHT_INC    = 2'b01,
    BHT_SET_ST = 2'b10
  } bht_op_e;

  // Saturating counter step
  function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input bht_op_e op);
    logic [1:0] c;
    c = cur;
    unique case (op)
      BHT_INC:    return (cur == ST)  ? ST  : bht_cnt_e'(2'(c + 2'd1));
      BHT_DEC:    return (cur == SNT) ? SNT : bht_cnt_e'(2'(c - 2'd1));
      BHT_SET_ST: return ST;
      default:    return cur;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX-facing signal bundle of the branch resolution unit.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic [XLEN-1:0]  if_pc;
  logic             bht_taken;

  logic             ex_valid;
  logic             ex_stall;
  logic             ex_is_branch;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_cond_taken;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;

  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic             btb_update;
  logic [XLEN-1:0]  btb_update_pc;
  logic [XLEN-1:0]  btb_update_target;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  // Pipeline side: drives fetch PC and EX instruction, observes results
  modport master (
    output if_pc, ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_pc, ex_cond_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  bht_taken, flush, redirect_pc, btb_update, btb_update_pc,
           btb_update_target, branch_cnt, mispredict_cnt
  );

  // Resolution unit side
  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_pc, ex_cond_taken, ex_target, ex_pred_taken, ex_pred_target,
    output bht_taken, flush, redirect_pc, btb_update, btb_update_pc,
           btb_update_target, branch_cnt, mispredict_cnt
  );

endinterface

// File: rtl/branch_resolve_unit_bht_counter_table.sv
// Table of 2-bit saturating direction counters: one async read, one sync update.
module bht_counter_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_BHT_ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output bht_cnt_e          rd_cnt_c_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  bht_op_e           wr_op_i
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  bht_cnt_e table_q [DEPTH];
  bht_cnt_e wr_cnt_d;

  // Read returns the pre-update value; no same-cycle bypass
  assign rd_cnt_c_o = table_q[rd_idx_i];

  // Next value of the entry being written
  always_comb begin
    wr_cnt_d = bht_next(table_q[wr_idx_i], wr_op_i);
  end

  // Counter storage with synchronous reset of every entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= BHT_RESET;
      end
    end else if (wr_en_i) begin
      table_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: mispredict flush/redirect, BTB write, BHT, stats.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned BHT_ADDR_LEN = DEF_BHT_ADDR_LEN,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  logic             accept;
  logic             is_ctrl;
  logic             actual_taken;
  logic [XLEN-1:0]  actual_next;
  logic             mispredict;
  logic             btb_wr;

  logic             flush_q, flush_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             btb_update_q, btb_update_d;
  logic [XLEN-1:0]  btb_update_pc_q, btb_update_pc_d;
  logic [XLEN-1:0]  btb_update_target_q, btb_update_target_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  bht_cnt_e         bht_rd_cnt;
  logic             bht_wr_en;
  bht_op_e          bht_wr_op;
  logic             unused_if_pc;

  assign unused_if_pc = ^{bus.if_pc[1:0], bus.if_pc[XLEN-1:BHT_ADDR_LEN+2]};

  bht_counter_table #(
    .ADDR_W (BHT_ADDR_LEN)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bus.if_pc[BHT_ADDR_LEN+1:2]),
    .rd_cnt_c_o (bht_rd_cnt),
    .wr_en_i    (bht_wr_en),
    .wr_idx_i   (bus.ex_pc[BHT_ADDR_LEN+1:2]),
    .wr_op_i    (bht_wr_op)
  );

  assign bus.bht_taken = (bht_rd_cnt == WT) || (bht_rd_cnt == ST);

  // Resolve the EX instruction against its fetch-time prediction
  always_comb begin
    accept       = bus.ex_valid && !bus.ex_stall && !flush_q;
    is_ctrl      = bus.ex_is_branch || bus.ex_is_jal || bus.ex_is_jalr;
    actual_taken = bus.ex_is_jal || bus.ex_is_jalr ||
                   (bus.ex_is_branch && bus.ex_cond_taken);
    actual_next  = actual_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
    mispredict   = accept && ((bus.ex_pred_taken != actual_taken) ||
                   (actual_taken && (bus.ex_pred_target != bus.ex_target)));
    btb_wr       = accept && actual_taken &&
                   (!bus.ex_pred_taken || (bus.ex_pred_target != bus.ex_target));
    bht_wr_en    = accept && is_ctrl;
    bht_wr_op    = (bus.ex_is_jal || bus.ex_is_jalr) ? BHT_SET_ST :
                   (bus.ex_cond_taken ? BHT_INC : BHT_DEC);
  end

  // Next values of the registered outputs and statistics
  always_comb begin
    flush_d             = mispredict;
    redirect_pc_d       = redirect_pc_q;
    btb_update_d        = btb_wr;
    btb_update_pc_d     = btb_update_pc_q;
    btb_update_target_d = btb_update_target_q;
    branch_cnt_d        = branch_cnt_q;
    mispredict_cnt_d    = mispredict_cnt_q;
    if (mispredict) begin
      redirect_pc_d    = actual_next;
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
    if (btb_wr) begin
      btb_update_pc_d     = bus.ex_pc;
      btb_update_target_d = bus.ex_target;
    end
    if (accept && is_ctrl) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_q             <= 1'b0;
      redirect_pc_q       <= '0;
      btb_update_q        <= 1'b0;
      btb_update_pc_q     <= '0;
      btb_update_target_q <= '0;
      branch_cnt_q        <= '0;
      mispredict_cnt_q    <= '0;
    end else begin
      flush_q             <= flush_d;
      redirect_pc_q       <= redirect_pc_d;
      btb_update_q        <= btb_update_d;
      btb_update_pc_q     <= btb_update_pc_d;
      btb_update_target_q <= btb_update_target_d;
      branch_cnt_q        <= branch_cnt_d;
      mispredict_cnt_q    <= mispredict_cnt_d;
    end
  end

  assign bus.flush             = flush_q;
  assign bus.redirect_pc       = redirect_pc_q;
  assign bus.btb_update        = btb_update_q;
  assign bus.btb_update_pc     = btb_update_pc_q;
  assign bus.btb_update_target = btb_update_target_q;
  assign bus.branch_cnt        = branch_cnt_q;
  assign bus.mispredict_cnt    = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic vs. a reference model.
module tb_branch_resolve_unit;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 32;
  localparam int unsigned NB = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(CW)) bus ();

  branch_resolve_unit #(.BHT_ADDR_LEN(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int          m_bht [NB];
  bit          m_flush;
  bit          m_upd;
  logic [31:0] m_redir, m_upd_pc, m_upd_tgt, m_bcnt, m_mcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 4) % NB);
  endfunction

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_flush = 0; m_upd = 0;
    m_redir = 0; m_upd_pc = 0; m_upd_tgt = 0; m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic check_outputs();
    check("flush", bus.flush, m_flush);
    check("redirect_pc", bus.redirect_pc, m_redir);
    check("btb_update", bus.btb_update, m_upd);
    check("btb_update_pc", bus.btb_update_pc, m_upd_pc);
    check("btb_update_target", bus.btb_update_target, m_upd_tgt);
    check("branch_cnt", bus.branch_cnt, m_bcnt);
    check("mispredict_cnt", bus.mispredict_cnt, m_mcnt);
  endtask

  task automatic drive(input bit v, st, br, jal, jalr, input logic [31:0] pc,
                       input bit cond, input logic [31:0] tgt, input bit pt,
                       input logic [31:0] ptgt, input logic [31:0] ifpc);
    bus.ex_valid = v;      bus.ex_stall = st;
    bus.ex_is_branch = br; bus.ex_is_jal = jal; bus.ex_is_jalr = jalr;
    bus.ex_pc = pc;        bus.ex_cond_taken = cond; bus.ex_target = tgt;
    bus.ex_pred_taken = pt; bus.ex_pred_target = ptgt;
    bus.if_pc = ifpc;
  endtask

  // One clock: apply an EX instruction, check the BHT read, advance model, check outputs
  task automatic cycle(input bit v, st, br, jal, jalr, input logic [31:0] pc,
                       input bit cond, input logic [31:0] tgt, input bit pt,
                       input logic [31:0] ptgt, input logic [31:0] ifpc);
    bit acc, taken, mis, upd;
    logic [31:0] nxt;
    @(negedge clk);
    rst = 1'b1;
    drive(v, st, br, jal, jalr, pc, cond, tgt, pt, ptgt, ifpc);
    assert ((int'(br) + int'(jal) + int'(jalr)) <= 1);
    #1;
    check("bht_taken", bus.bht_taken, m_bht[bidx(ifpc)] >= 2);
    acc   = v && !st && !m_flush;
    taken = jal || jalr || (br && cond);
    nxt   = taken ? tgt : pc + 32'd4;
    mis   = acc && ((pt != taken) || (taken && ptgt != tgt));
    upd   = acc && taken && (!pt || ptgt != tgt);
    @(posedge clk);
    #1;
    m_flush = mis;
    m_upd   = upd;
    if (mis) begin
      m_redir = nxt;
      m_mcnt  = m_mcnt + 1;
    end
    if (upd) begin
      m_upd_pc  = pc;
      m_upd_tgt = tgt;
    end
    if (acc && br) m_bht[bidx(pc)] = cond ? ((m_bht[bidx(pc)] == 3) ? 3 : m_bht[bidx(pc)] + 1)
                                          : ((m_bht[bidx(pc)] == 0) ? 0 : m_bht[bidx(pc)] - 1);
    if (acc && (jal || jalr)) m_bht[bidx(pc)] = 3;
    if (acc && (br || jal || jalr)) m_bcnt = m_bcnt + 1;
    check_outputs();
  endtask

  task automatic idle(input logic [31:0] ifpc);
    cycle(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, ifpc);
  endtask

  // Reset with a mispredicting branch presented in the same cycle
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 1, 0, 0, 32'h100, 1, 32'h200, 0, 32'h0, 32'h100);
    @(posedge clk);
    #1;
    model_reset();
    check("rst_flush", bus.flush, 32'h0);
    check("rst_bht_taken", bus.bht_taken, 32'h0);
    check_outputs();
  endtask

  logic [31:0] save_b, save_m;

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    do_reset();

    // Taken branch predicted not-taken
    cycle(1, 0, 1, 0, 0, 32'h100, 1, 32'h200, 0, 32'h0, 32'h100);
    check("d1_flush", bus.flush, 32'h1);
    check("d1_redirect", bus.redirect_pc, 32'h200);
    check("d1_btb_upd", bus.btb_update, 32'h1);
    check("d1_btb_pc", bus.btb_update_pc, 32'h100);
    check("d1_btb_tgt", bus.btb_update_target, 32'h200);
    check("d1_mcnt", bus.mispredict_cnt, 32'h1);
    idle(32'h100);
    check("d1_bht_taken", bus.bht_taken, 32'h1);

    // Predicted taken, actually not taken, then saturation at SNT
    cycle(1, 0, 1, 0, 0, 32'h100, 0, 32'h200, 1, 32'h200, 32'h100);
    check("d2_flush", bus.flush, 32'h1);
    check("d2_redirect", bus.redirect_pc, 32'h104);
    check("d2_btb_upd", bus.btb_update, 32'h0);
    idle(32'h100);
    cycle(1, 0, 1, 0, 0, 32'h100, 0, 32'h200, 0, 32'h0, 32'h100);
    cycle(1, 0, 1, 0, 0, 32'h100, 0, 32'h200, 0, 32'h0, 32'h100);
    check("d2_sat_model", m_bht[bidx(32'h100)], 32'h0);
    cycle(1, 0, 1, 0, 0, 32'h100, 1, 32'h200, 0, 32'h0, 32'h100);
    idle(32'h100);
    check("d2_after_sat", bus.bht_taken, 32'h0);

    // JALR wrong target, then a mispredict presented during the flush
    cycle(1, 0, 0, 0, 1, 32'h400, 0, 32'h340, 1, 32'h300, 32'h400);
    check("d3_flush", bus.flush, 32'h1);
    check("d3_redirect", bus.redirect_pc, 32'h340);
    check("d3_btb_tgt", bus.btb_update_target, 32'h340);
    save_b = m_bcnt; save_m = m_mcnt;
    cycle(1, 0, 1, 0, 0, 32'h180, 1, 32'h280, 0, 32'h0, 32'h400);
    check("d3_no_reflush", bus.flush, 32'h0);
    check("d3_bcnt_held", bus.branch_cnt, save_b);
    check("d3_mcnt_held", bus.mispredict_cnt, save_m);

    // Correctly predicted taken branch
    save_b = m_bcnt; save_m = m_mcnt;
    cycle(1, 0, 1, 0, 0, 32'h100, 1, 32'h200, 1, 32'h200, 32'h100);
    check("d4_flush", bus.flush, 32'h0);
    check("d4_btb_upd", bus.btb_update, 32'h0);
    check("d4_bcnt", bus.branch_cnt, save_b + 1);
    check("d4_mcnt", bus.mispredict_cnt, save_m);

    // Stalled mispredict acts only once released
    cycle(1, 1, 1, 0, 0, 32'h180, 1, 32'h280, 0, 32'h0, 32'h180);
    cycle(1, 1, 1, 0, 0, 32'h180, 1, 32'h280, 0, 32'h0, 32'h180);
    check("d5_stalled", bus.flush, 32'h0);
    cycle(1, 0, 1, 0, 0, 32'h180, 1, 32'h280, 0, 32'h0, 32'h180);
    check("d5_released", bus.flush, 32'h1);
    check("d5_redirect", bus.redirect_pc, 32'h280);
    idle(32'h0);

    // Aliased ALU op at the top of the address space
    save_b = m_bcnt;
    cycle(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 32'hFFFF_FFFC);
    check("d6_flush", bus.flush, 32'h1);
    check("d6_redirect", bus.redirect_pc, 32'h0);
    check("d6_bcnt", bus.branch_cnt, save_b);

    // Mid-run reset with a mispredict pending
    idle(32'h0);
    cycle(1, 0, 0, 1, 0, 32'h140, 0, 32'h500, 0, 32'h0, 32'h140);
    do_reset();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      int unsigned ty;
      logic [31:0] pc, tgt, ptgt, ifpc;
      ty   = $urandom_range(0, 3);
      pc   = 32'h100 + 4 * $urandom_range(0, 31);
      if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FFFC;
      tgt  = 32'h200 + 4 * $urandom_range(0, 7);
      ptgt = ($urandom_range(0, 1) == 1) ? tgt : 32'h200 + 4 * $urandom_range(0, 7);
      ifpc = 32'h100 + 4 * $urandom_range(0, 31);
      if (k % 700 == 699) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
              ty == 1, ty == 2, ty == 3, pc, 1'($urandom_range(0, 1)), tgt,
              1'($urandom_range(0, 1)), ptgt, ifpc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
